// File: rtl/multi_sched.sv
// multi_sched: time-multiplexed RADIX x RADIX unsigned multiplier. One a-limb row per cycle is
// multiplied against every b-limb in parallel, and the shifted rows are summed into a 2*RADIX-bit product.
module multi_sched #(
    parameter int RADIX   = 78,
    parameter int A_LIMB  = 26,
    parameter int B_LIMB  = 17,
    parameter int DSP_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RADIX-1:0]     a,
    input  logic [RADIX-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*RADIX-1:0]   res
);

    localparam int NA = (RADIX + A_LIMB - 1) / A_LIMB;
    localparam int NB = (RADIX + B_LIMB - 1) / B_LIMB;
    localparam int AW = NA * A_LIMB;
    localparam int BW = NB * B_LIMB;
    localparam int PW = A_LIMB + B_LIMB;
    localparam int RW = 2 * RADIX;
    localparam int CW = (NA > 1) ? $clog2(NA) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [AW-1:0]      r_a;
    logic [BW-1:0]      r_b;
    logic [PW-1:0]      r_pp   [DSP_LAT][NB];
    logic [CW-1:0]      r_idx  [DSP_LAT];
    logic [DSP_LAT-1:0] r_vld;
    logic [DSP_LAT-1:0] r_last;
    logic [RW-1:0]      r_acc;
    logic               w_issue;
    logic               w_accept;
    logic               w_last_row;
    logic [A_LIMB-1:0]  w_alimb;
    logic [RW-1:0]      w_row;
    logic [RW-1:0]      w_row_sh;

    function automatic logic [PW-1:0] limb_mul(input logic [A_LIMB-1:0] x,
                                               input logic [B_LIMB-1:0] y);
        return PW'(x) * PW'(y);
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_last_row = (r_cnt == CW'(NA - 1));
    assign w_alimb    = r_a[int'(r_cnt) * A_LIMB +: A_LIMB];
    assign res        = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ISSUE;
            S_ISSUE: if (w_last_row) w_next = S_DRAIN;
            // Leave DRAIN on the same edge that folds the final row into the accumulator.
            S_DRAIN: if (r_vld[DSP_LAT-1] && r_last[DSP_LAT-1]) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_ISSUE: w_issue   = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_issue && !w_last_row) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Operands zero-padded up to whole limbs so the top limbs read as zero.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= AW'(a);
            r_b <= BW'(b);
        end
    end

    // Multiplier pipeline: product at stage 0, delayed through the remaining DSP stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld[0]  <= w_issue;
            r_last[0] <= w_issue && w_last_row;
            for (int k = 1; k < DSP_LAT; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_last[k] <= r_last[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NB; j++) begin
            r_pp[0][j] <= limb_mul(w_alimb, r_b[j*B_LIMB +: B_LIMB]);
        end
        r_idx[0] <= r_cnt;
        for (int k = 1; k < DSP_LAT; k++) begin
            r_pp[k]  <= r_pp[k-1];
            r_idx[k] <= r_idx[k-1];
        end
    end

    // Row sum and shift are truncated to RW bits; the exact product never exceeds that width.
    always_comb begin
        w_row = '0;
        for (int j = 0; j < NB; j++) begin
            w_row = w_row + (RW'(r_pp[DSP_LAT-1][j]) << (j * B_LIMB));
        end
        w_row_sh = w_row << (int'(r_idx[DSP_LAT-1]) * A_LIMB);
    end

    // Accumulate stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_vld[DSP_LAT-1]) begin
            r_acc <= r_acc + w_row_sh;
        end
    end

endmodule

// File: tb/tb_multi_sched.sv
// Bench for multi_sched: directed vector tables, backpressure/reset sequences and random
// back-to-back traffic against a golden a*b model, for two parameter sets.
module tb_multi_sched;

    localparam int R1 = 78, A1 = 26, B1 = 17, D1 = 3;
    localparam int R2 = 64, A2 = 24, B2 = 16, D2 = 4;

    typedef struct {
        logic [77:0]  a;
        logic [77:0]  b;
        logic [155:0] r;
        string        nm;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         tb_in_valid;
    logic         tb_out_ready;
    logic [77:0]  tb_a;
    logic [77:0]  tb_b;
    logic         ir1, ov1, ir2, ov2;
    logic [155:0] res1;
    logic [127:0] res2;
    logic         m_in_ready;
    logic         m_out_valid;
    logic [155:0] m_res;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_lat;

    always #5 clk = ~clk;

    assign m_in_ready  = sel ? ir2 : ir1;
    assign m_out_valid = sel ? ov2 : ov1;
    assign m_res       = sel ? {28'b0, res2} : res1;

    multi_sched #(.RADIX(R1), .A_LIMB(A1), .B_LIMB(B1), .DSP_LAT(D1)) dut (
        .clk(clk), .rst(rst), .in_valid(tb_in_valid & ~sel), .in_ready(ir1),
        .a(tb_a), .b(tb_b), .out_valid(ov1), .out_ready(tb_out_ready), .res(res1)
    );

    multi_sched #(.RADIX(R2), .A_LIMB(A2), .B_LIMB(B2), .DSP_LAT(D2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(tb_in_valid & sel), .in_ready(ir2),
        .a(tb_a[63:0]), .b(tb_b[63:0]), .out_valid(ov2), .out_ready(tb_out_ready), .res(res2)
    );

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int calc_lat(input int r, input int al, input int dl);
        return (r + al - 1) / al + dl + 1;
    endfunction

    function automatic logic [77:0] rnd_op(input int r);
        logic [95:0] w;
        logic [77:0] m;
        w = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 9))
            0: w = '0;
            1: w = '1;
            default: ;
        endcase
        m = '1;
        m = m >> (78 - r);
        return w[77:0] & m;
    endfunction

    function automatic logic [155:0] gold(input logic [77:0] x, input logic [77:0] y);
        return 156'(x) * 156'(y);
    endfunction

    function automatic logic [155:0] max_sq(input int r);
        logic [156:0] t;
        t = (157'(1) << (2 * r)) - (157'(1) << (r + 1)) + 157'(1);
        return t[155:0];
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen (or one later if released).
    task automatic do_op(input logic [77:0] av, input logic [77:0] bv,
                         input logic [155:0] ex, input string nm);
        int n;
        int bad;
        n = 0;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready"}, 160'(m_in_ready), 160'(1));
        tb_a = av;
        tb_b = bv;
        tb_in_valid = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b0;
        tb_a = rnd_op(78);
        tb_b = rnd_op(78);
        n = 1;
        bad = 0;
        while (!m_out_valid && n < 100) begin
            if (m_in_ready) bad++;
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 160'(n), 160'(cur_lat));
        check({nm, " busy_ready"}, 160'(bad), 160'(0));
        check({nm, " res"}, 160'(m_res), 160'(ex));
        if (tb_out_ready) begin
            @(negedge clk);
            check({nm, " release"}, {158'(0), m_out_valid, m_in_ready}, 160'(1));
        end
    endtask

    task automatic run_b2b(input int nops, input int r, input string nm);
        logic [155:0] qe[$];
        int           qc[$];
        logic [155:0] ex;
        int cyc, issued, got, last_out, budget, ac;
        cyc = 0;
        issued = 0;
        got = 0;
        last_out = -1;
        budget = nops * (cur_lat + 1) + 100;
        tb_out_ready = 1'b1;
        tb_in_valid = 1'b0;
        while (got < nops && cyc < budget) begin
            if (m_out_valid) begin
                if (qe.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s unexpected: got out_valid at cycle %0d, expected none", nm, cyc);
                end else begin
                    ex = qe.pop_front();
                    ac = qc.pop_front();
                    check({nm, " res"}, 160'(m_res), 160'(ex));
                    check({nm, " latency"}, 160'(cyc - ac), 160'(cur_lat));
                    if (last_out >= 0) check({nm, " spacing"}, 160'(cyc - last_out), 160'(cur_lat + 1));
                    last_out = cyc;
                    got++;
                end
            end
            if (m_in_ready) begin
                if (issued < nops) begin
                    tb_a = rnd_op(r);
                    tb_b = rnd_op(r);
                    qe.push_back(gold(tb_a, tb_b));
                    qc.push_back(cyc);
                    tb_in_valid = 1'b1;
                    issued++;
                end else begin
                    tb_in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tb_in_valid = 1'b0;
        check({nm, " count"}, 160'(got), 160'(nops));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t         v1[7];
        vec_t         v2[3];
        logic [77:0]  mx;
        logic [77:0]  mx64;
        logic [155:0] held;
        int           cnt;

        mx   = '1;
        mx64 = 78'(64'hFFFF_FFFF_FFFF_FFFF);
        v1[0] = '{78'd1, 78'd1, 156'd1, "one"};
        v1[1] = '{mx, mx, max_sq(78), "max_max"};
        v1[2] = '{78'd0, mx, 156'd0, "zero_max"};
        v1[3] = '{mx, 78'd1, 156'(mx), "max_one"};
        v1[4] = '{78'(1) << 77, 78'(1) << 77, 156'(1) << 154, "top_bits"};
        v1[5] = '{78'((1 << 26) - 1), 78'(1) << 17, 156'((1 << 26) - 1) << 17, "limb_edge"};
        v1[6] = '{78'd3, 78'd5, 156'd15, "small"};
        v2[0] = '{78'd1, 78'd1, 156'd1, "p2_one"};
        v2[1] = '{mx64, mx64, max_sq(64), "p2_max_max"};
        v2[2] = '{78'd0, mx64, 156'd0, "p2_zero_max"};

        rst = 1'b1;
        sel = 1'b0;
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b1;
        tb_a = '0;
        tb_b = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {158'(0), m_out_valid, m_in_ready}, 160'(1));
        check("reset_res", 160'(m_res), 160'(0));
        sel = 1'b1;
        #1;
        check("p2_reset_ctrl", {158'(0), m_out_valid, m_in_ready}, 160'(1));
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        cur_lat = calc_lat(R1, A1, D1);
        for (int i = 0; i < 7; i++) do_op(v1[i].a, v1[i].b, v1[i].r, v1[i].nm);

        // Backpressure: result and flags frozen, stray in_valid pulses ignored.
        tb_out_ready = 1'b0;
        tb_a = rnd_op(78);
        tb_b = rnd_op(78);
        do_op(tb_a, tb_b, gold(tb_a, tb_b), "bp");
        held = m_res;
        for (int k = 0; k < 20; k++) begin
            tb_in_valid = 1'($urandom_range(0, 1));
            tb_a = rnd_op(78);
            tb_b = rnd_op(78);
            @(negedge clk);
            check("bp_hold", {2'b00, m_out_valid, m_in_ready, m_res}, {2'b00, 1'b1, 1'b0, held});
        end
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {158'(0), m_out_valid, m_in_ready}, 160'(1));
        cnt = 0;
        repeat (cur_lat + 2) begin
            @(negedge clk);
            if (m_out_valid || !m_in_ready) cnt++;
        end
        check("bp_no_ghost", 160'(cnt), 160'(0));

        // Reset during ISSUE aborts the operation with no partial result.
        tb_a = mx;
        tb_b = mx;
        tb_in_valid = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_abort_ctrl", {158'(0), m_out_valid, m_in_ready}, 160'(1));
        check("rst_abort_res", 160'(m_res), 160'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (cur_lat + 3) begin
            @(negedge clk);
            if (m_out_valid) cnt++;
        end
        check("rst_no_result", 160'(cnt), 160'(0));
        do_op(78'd3, 78'd5, 156'd15, "after_rst");

        run_b2b(1000, R1, "b2b");

        sel = 1'b1;
        cur_lat = calc_lat(R2, A2, D2);
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_op(v2[i].a, v2[i].b, v2[i].r, v2[i].nm);
        run_b2b(300, R2, "p2_b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
